usb_fs_in_pe_pingpong: RTL and testbench

Double-buffered, parametrised USB full-speed IN protocol engine: accepts packet data from up to NUM_IN_EPS endpoint producers into two packet slots per endpoint and answers IN tokens with DATA0/1, NAK, STALL or (isochronous) zero-length DATA0. Sits between the USB FS rx/tx packet layers and the endpoint logic. Adds the following over the single-buffered engine:
- ping-pong slots, so a producer can fill the next packet while the current one is awaiting ACK;
- per-endpoint isochronous mode;
- an ACK timeout.

---
 rtl/usb_fs_pkg.sv | 25 ++
 rtl/usb_fs_in_ep_slots.sv | 108 ++++++++++
 rtl/usb_fs_in_pe_pingpong.sv | 212 +++++++++++++++++++++
 tb/tb_usb_fs_in_pe_pingpong.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed definitions: PID codes and the state encodings
// used by the IN protocol engine and its per-endpoint slot trackers.
package usb_fs_pkg;

   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;

   typedef enum logic {
      EP_ACTIVE,
      EP_STALLED
   } ep_state_t;

   typedef enum logic [1:0] {
      XFER_IDLE,
      XFER_RCVD_IN,
      XFER_SEND_DATA,
      XFER_WAIT_ACK
   } xfer_state_t;

endpackage

// File: rtl/usb_fs_in_ep_slots.sv
// Ping-pong slot bookkeeping for one IN endpoint: fill/drain pointers, per-slot
// valid and length, put address, data toggle and stall flag.
module usb_fs_in_ep_slots
   import usb_fs_pkg::*;
#(
   parameter int unsigned AW = 5
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_flush_ep,
   input  logic          i_flush_setup,
   input  logic          i_stall_set,
   input  logic          i_put,
   input  logic          i_done,
   input  logic          i_release,
   input  logic          i_toggle_flip,
   output logic          o_free,
   output logic          o_wr_en,
   output logic [AW:0]   o_wr_addr,
   output logic          o_dsel,
   output logic          o_dvalid,
   output logic [AW:0]   o_dlen,
   output logic          o_toggle,
   output logic          o_stalled
);

   localparam logic [AW:0] MaxLen = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] PutOne = {{AW{1'b0}}, 1'b1};

   logic [1:0]         r_valid;
   logic [1:0][AW:0]   r_len;
   logic               r_fsel;
   logic               r_dsel;
   logic               r_toggle;
   logic               r_ready;
   logic [AW:0]        r_put_addr;
   ep_state_t          r_state;

   logic               w_flush;
   logic               w_free;
   logic               w_wr_en;
   logic               w_commit;
   logic [AW:0]        w_put_next;

   always_comb begin
      w_flush    = i_flush_ep || i_flush_setup;
      w_free     = r_ready && !r_valid[r_fsel] && (r_state == EP_ACTIVE);
      w_wr_en    = i_put && w_free && !w_flush;
      w_put_next = r_put_addr + PutOne;
      // A full slot commits on its last byte without waiting for done.
      w_commit   = w_free && !w_flush && (i_done || (i_put && (w_put_next == MaxLen)));
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush_ep) begin
         r_valid    <= '0;
         r_len      <= '0;
         r_fsel     <= 1'b0;
         r_dsel     <= 1'b0;
         r_put_addr <= '0;
         r_toggle   <= 1'b0;
         r_state    <= EP_ACTIVE;
         r_ready    <= !i_reset;
      end else if (i_flush_setup) begin
         r_valid    <= '0;
         r_len      <= '0;
         r_fsel     <= 1'b0;
         r_dsel     <= 1'b0;
         r_put_addr <= '0;
         r_toggle   <= 1'b1;
         r_state    <= EP_ACTIVE;
         r_ready    <= 1'b1;
      end else begin
         r_ready <= 1'b1;
         if (w_wr_en) begin
            r_put_addr <= w_put_next;
         end
         if (w_commit) begin
            r_valid[r_fsel] <= 1'b1;
            r_len[r_fsel]   <= w_wr_en ? w_put_next : r_put_addr;
            r_fsel          <= !r_fsel;
            r_put_addr      <= '0;
         end
         // Commit needs the fill slot empty, release needs the drain slot full,
         // so the two never touch the same slot.
         if (i_release && r_valid[r_dsel]) begin
            r_valid[r_dsel] <= 1'b0;
            r_dsel          <= !r_dsel;
            if (i_toggle_flip) begin
               r_toggle <= !r_toggle;
            end
         end
         if (i_stall_set) begin
            r_state <= EP_STALLED;
         end
      end
   end

   assign o_free    = w_free;
   assign o_wr_en   = w_wr_en;
   assign o_wr_addr = {r_fsel, r_put_addr[AW-1:0]};
   assign o_dsel    = r_dsel;
   assign o_dvalid  = r_valid[r_dsel];
   assign o_dlen    = r_len[r_dsel];
   assign o_toggle  = r_toggle;
   assign o_stalled = (r_state == EP_STALLED);

endmodule

// File: rtl/usb_fs_in_pe_pingpong.sv
// Double-buffered USB FS IN protocol engine: shared packet RAM, token decode and
// the IN transfer FSM answering with DATA0/1, NAK, STALL or isochronous DATA0.
module usb_fs_in_pe_pingpong
   import usb_fs_pkg::*;
#(
   parameter int unsigned           NUM_IN_EPS         = 11,
   parameter int unsigned           MAX_IN_PACKET_SIZE = 32,
   parameter int unsigned           ACK_TIMEOUT        = 1024,
   parameter logic [NUM_IN_EPS-1:0] ISO_EPS            = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_IN_EPS-1:0] reset_ep,
   input  logic [6:0]            dev_addr,
   output logic [NUM_IN_EPS-1:0] in_ep_data_free,
   input  logic [NUM_IN_EPS-1:0] in_ep_data_put,
   input  logic [7:0]            in_ep_data,
   input  logic [NUM_IN_EPS-1:0] in_ep_data_done,
   input  logic [NUM_IN_EPS-1:0] in_ep_stall,
   output logic [NUM_IN_EPS-1:0] in_ep_acked,
   input  logic                  rx_pkt_start,
   input  logic                  rx_pkt_end,
   input  logic                  rx_pkt_valid,
   input  logic [3:0]            rx_pid,
   input  logic [6:0]            rx_addr,
   input  logic [3:0]            rx_endp,
   input  logic [10:0]           rx_frame_num,
   output logic                  tx_pkt_start,
   input  logic                  tx_pkt_end,
   output logic [3:0]            tx_pid,
   output logic                  tx_data_avail,
   input  logic                  tx_data_get,
   output logic [7:0]            tx_data
);

   localparam int unsigned AW = $clog2(MAX_IN_PACKET_SIZE);
   localparam int unsigned EW = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;
   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [AW:0] GetOne   = {{AW{1'b0}}, 1'b1};
   localparam logic [TW-1:0] TimerOne = {{(TW-1){1'b0}}, 1'b1};

   logic [7:0] r_mem [NUM_IN_EPS][2][MAX_IN_PACKET_SIZE];

   xfer_state_t           r_state;
   logic [EW-1:0]         r_cur_ep;
   logic [AW:0]           r_get_addr;
   logic [TW-1:0]         r_timer;
   logic                  r_has_data;
   logic                  r_tx_pkt_start;
   logic [3:0]            r_tx_pid;
   logic [7:0]            r_tx_data;
   logic [NUM_IN_EPS-1:0] r_acked;

   logic [NUM_IN_EPS-1:0] w_free;
   logic [NUM_IN_EPS-1:0] w_wr_en;
   logic [NUM_IN_EPS-1:0] w_dsel;
   logic [NUM_IN_EPS-1:0] w_dvalid;
   logic [NUM_IN_EPS-1:0] w_toggle;
   logic [NUM_IN_EPS-1:0] w_stalled;
   logic [NUM_IN_EPS-1:0] w_release;
   logic [AW:0]           w_wr_addr [NUM_IN_EPS];
   logic [AW:0]           w_dlen [NUM_IN_EPS];

   logic          w_tok;
   logic          w_in_tok;
   logic          w_setup_tok;
   logic          w_ack;
   logic [EW-1:0] w_rx_ep;
   logic          w_tok_has_data;
   logic [3:0]    w_tok_pid;
   logic          w_cur_iso;
   logic          w_ack_rel;
   logic          w_iso_rel;
   logic          w_avail;
   logic          w_cur_flush;
   logic          w_unused;

   assign w_unused = ^{rx_pkt_start, rx_frame_num};

   always_comb begin
      w_tok = rx_pkt_end && rx_pkt_valid && (rx_pid[1:0] == 2'b01) &&
              (rx_addr == dev_addr) && ({1'b0, rx_endp} < 5'(NUM_IN_EPS));
      w_in_tok       = w_tok && (rx_pid[3:2] == 2'b10);
      w_setup_tok    = w_tok && (rx_pid[3:2] == 2'b11);
      w_ack          = rx_pkt_end && rx_pkt_valid && (rx_pid == PID_ACK);
      w_rx_ep        = rx_endp[EW-1:0];
      w_tok_has_data = w_dvalid[w_rx_ep] && !w_stalled[w_rx_ep];
      if (w_stalled[w_rx_ep]) begin
         w_tok_pid = PID_STALL;
      end else if (ISO_EPS[w_rx_ep]) begin
         w_tok_pid = PID_DATA0;
      end else if (w_dvalid[w_rx_ep]) begin
         w_tok_pid = {w_toggle[w_rx_ep], 3'b011};
      end else begin
         w_tok_pid = PID_NAK;
      end
      w_cur_iso   = ISO_EPS[r_cur_ep];
      w_ack_rel   = (r_state == XFER_WAIT_ACK) && w_ack;
      w_iso_rel   = (r_state == XFER_SEND_DATA) && tx_pkt_end && w_cur_iso;
      w_avail     = (r_state == XFER_SEND_DATA) && r_has_data &&
                    (r_get_addr < w_dlen[r_cur_ep]);
      w_cur_flush = reset_ep[r_cur_ep];
   end

   for (genvar i = 0; i < NUM_IN_EPS; i++) begin : g_ep
      assign w_release[i] = (r_cur_ep == EW'(i)) && r_has_data && (w_ack_rel || w_iso_rel);

      usb_fs_in_ep_slots #(
         .AW (AW)
      ) u_slots (
         .i_clk         (clk),
         .i_reset       (reset),
         .i_flush_ep    (reset_ep[i]),
         .i_flush_setup (w_setup_tok && (w_rx_ep == EW'(i))),
         .i_stall_set   (in_ep_stall[i]),
         .i_put         (in_ep_data_put[i]),
         .i_done        (in_ep_data_done[i]),
         .i_release     (w_release[i]),
         .i_toggle_flip (w_ack_rel),
         .o_free        (w_free[i]),
         .o_wr_en       (w_wr_en[i]),
         .o_wr_addr     (w_wr_addr[i]),
         .o_dsel        (w_dsel[i]),
         .o_dvalid      (w_dvalid[i]),
         .o_dlen        (w_dlen[i]),
         .o_toggle      (w_toggle[i]),
         .o_stalled     (w_stalled[i])
      );
   end

   always_ff @(posedge clk) begin
      for (int n = 0; n < NUM_IN_EPS; n++) begin
         if (w_wr_en[n]) begin
            r_mem[n][w_wr_addr[n][AW]][w_wr_addr[n][AW-1:0]] <= in_ep_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= XFER_IDLE;
         r_cur_ep       <= '0;
         r_get_addr     <= '0;
         r_timer        <= '0;
         r_has_data     <= 1'b0;
         r_tx_pkt_start <= 1'b0;
         r_tx_pid       <= '0;
         r_tx_data      <= '0;
         r_acked        <= '0;
      end else begin
         r_tx_pkt_start <= 1'b0;
         r_tx_data      <= r_mem[r_cur_ep][w_dsel[r_cur_ep]][r_get_addr[AW-1:0]];
         r_acked        <= w_release & w_dvalid & ~reset_ep;
         case (r_state)
            XFER_IDLE: begin
               r_get_addr <= '0;
               // The handshake PID is chosen at token time so tx_pkt_start
               // can follow the token by exactly one cycle.
               if (w_in_tok) begin
                  r_cur_ep       <= w_rx_ep;
                  r_tx_pkt_start <= 1'b1;
                  r_tx_pid       <= w_tok_pid;
                  r_has_data     <= w_tok_has_data;
                  r_state        <= XFER_RCVD_IN;
               end
            end
            XFER_RCVD_IN: begin
               r_state <= (r_tx_pid[1:0] == 2'b11) ? XFER_SEND_DATA : XFER_IDLE;
            end
            XFER_SEND_DATA: begin
               if (tx_data_get && w_avail) begin
                  r_get_addr <= r_get_addr + GetOne;
               end
               if (tx_pkt_end) begin
                  r_timer <= '0;
                  r_state <= w_cur_iso ? XFER_IDLE : XFER_WAIT_ACK;
               end
            end
            XFER_WAIT_ACK: begin
               r_timer <= r_timer + TimerOne;
               if (w_ack) begin
                  r_state <= XFER_IDLE;
               end else if (w_in_tok) begin
                  r_get_addr     <= '0;
                  r_cur_ep       <= w_rx_ep;
                  r_tx_pkt_start <= 1'b1;
                  r_tx_pid       <= w_tok_pid;
                  r_has_data     <= w_tok_has_data;
                  r_state        <= XFER_RCVD_IN;
               end else if (rx_pkt_end || (r_timer == TW'(ACK_TIMEOUT))) begin
                  r_get_addr <= '0;
                  r_state    <= XFER_IDLE;
               end
            end
            default: r_state <= XFER_IDLE;
         endcase
         if (w_cur_flush && (r_state != XFER_IDLE)) begin
            r_state        <= XFER_IDLE;
            r_has_data     <= 1'b0;
            r_tx_pkt_start <= 1'b0;
         end
      end
   end

   assign in_ep_data_free = w_free;
   assign in_ep_acked     = r_acked;
   assign tx_pkt_start    = r_tx_pkt_start;
   assign tx_pid          = r_tx_pid;
   assign tx_data_avail   = w_avail;
   assign tx_data         = r_tx_data;

endmodule

// File: tb/tb_usb_fs_in_pe_pingpong.sv
// Directed bench for the ping-pong IN engine: full/short packets, ping-pong fill,
// ACK timeout, stall/SETUP, isochronous endpoint and mid-transfer reset.
module tb_usb_fs_in_pe_pingpong;

   localparam int unsigned NEPS = 11;
   localparam logic [6:0]  DEV  = 7'h2A;
   localparam logic [3:0]  P_DATA0 = 4'b0011;
   localparam logic [3:0]  P_DATA1 = 4'b1011;
   localparam logic [3:0]  P_ACK   = 4'b0010;
   localparam logic [3:0]  P_NAK   = 4'b1010;
   localparam logic [3:0]  P_STALL = 4'b1110;
   localparam logic [3:0]  P_IN    = 4'b1001;
   localparam logic [3:0]  P_SETUP = 4'b1101;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NEPS-1:0] reset_ep = '0;
   logic [NEPS-1:0] in_ep_data_free;
   logic [NEPS-1:0] in_ep_data_put = '0;
   logic [7:0]      in_ep_data = '0;
   logic [NEPS-1:0] in_ep_data_done = '0;
   logic [NEPS-1:0] in_ep_stall = '0;
   logic [NEPS-1:0] in_ep_acked;
   logic            rx_pkt_start = 1'b0;
   logic            rx_pkt_end = 1'b0;
   logic            rx_pkt_valid = 1'b0;
   logic [3:0]      rx_pid = '0;
   logic [6:0]      rx_addr = '0;
   logic [3:0]      rx_endp = '0;
   logic [10:0]     rx_frame_num = '0;
   logic            tx_pkt_start;
   logic            tx_pkt_end = 1'b0;
   logic [3:0]      tx_pid;
   logic            tx_data_avail;
   logic            tx_data_get = 1'b0;
   logic [7:0]      tx_data;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   usb_fs_in_pe_pingpong #(
      .NUM_IN_EPS         (NEPS),
      .MAX_IN_PACKET_SIZE (32),
      .ACK_TIMEOUT        (16),
      .ISO_EPS            (11'h010)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .reset_ep        (reset_ep),
      .dev_addr        (DEV),
      .in_ep_data_free (in_ep_data_free),
      .in_ep_data_put  (in_ep_data_put),
      .in_ep_data      (in_ep_data),
      .in_ep_data_done (in_ep_data_done),
      .in_ep_stall     (in_ep_stall),
      .in_ep_acked     (in_ep_acked),
      .rx_pkt_start    (rx_pkt_start),
      .rx_pkt_end      (rx_pkt_end),
      .rx_pkt_valid    (rx_pkt_valid),
      .rx_pid          (rx_pid),
      .rx_addr         (rx_addr),
      .rx_endp         (rx_endp),
      .rx_frame_num    (rx_frame_num),
      .tx_pkt_start    (tx_pkt_start),
      .tx_pkt_end      (tx_pkt_end),
      .tx_pid          (tx_pid),
      .tx_data_avail   (tx_data_avail),
      .tx_data_get     (tx_data_get),
      .tx_data         (tx_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put_bytes(input int ep, input int n, input logic [7:0] first);
      for (int i = 0; i < n; i++) begin
         in_ep_data_put = NEPS'(1) << ep;
         in_ep_data     = first + 8'(i);
         tick();
      end
      in_ep_data_put = '0;
   endtask

   task automatic commit(input int ep);
      in_ep_data_done = NEPS'(1) << ep;
      tick();
      in_ep_data_done = '0;
   endtask

   task automatic rx_packet(input logic [3:0] pid, input logic [3:0] ep, input logic [6:0] addr);
      rx_pkt_end   = 1'b1;
      rx_pkt_valid = 1'b1;
      rx_pid       = pid;
      rx_endp      = ep;
      rx_addr      = addr;
      tick();
      rx_pkt_end   = 1'b0;
      rx_pkt_valid = 1'b0;
      rx_pid       = '0;
      rx_endp      = '0;
      rx_addr      = '0;
   endtask

   task automatic in_xfer(input string tag, input logic [3:0] ep, input logic [3:0] exp_pid);
      rx_packet(P_IN, ep, DEV);
      check({tag, "_start"}, tx_pkt_start, 1);
      check({tag, "_pid"}, tx_pid, exp_pid);
      tick();
      check({tag, "_start_low"}, tx_pkt_start, 0);
   endtask

   task automatic recv_bytes(input string tag, input logic [7:0] first, input int n);
      logic [7:0] e;
      for (int i = 0; i < n; i++) begin
         e = first + 8'(i);
         check({tag, "_avail"}, tx_data_avail, 1);
         check({tag, "_data"}, tx_data, e);
         tx_data_get = 1'b1;
         tick();
         tx_data_get = 1'b0;
         tick();
      end
      check({tag, "_avail_end"}, tx_data_avail, 0);
   endtask

   task automatic pkt_end();
      tx_pkt_end = 1'b1;
      tick();
      tx_pkt_end = 1'b0;
   endtask

   task automatic ack_expect(input string tag, input logic [NEPS-1:0] exp);
      rx_packet(P_ACK, 4'd0, DEV);
      check({tag, "_acked"}, in_ep_acked, exp);
      tick();
      check({tag, "_acked_low"}, in_ep_acked, 0);
   endtask

   initial begin
      logic [NEPS-1:0] seen;

      // Reset values
      tick();
      tick();
      check("rst_start", tx_pkt_start, 0);
      check("rst_pid", tx_pid, 0);
      check("rst_data", tx_data, 0);
      check("rst_avail", tx_data_avail, 0);
      check("rst_acked", in_ep_acked, 0);
      check("rst_free", in_ep_data_free, 0);
      reset = 1'b0;
      check("rst_free_hold", in_ep_data_free, 0);
      tick();
      check("rst_free_rise", in_ep_data_free, 11'h7FF);

      // Full 32-byte packet on ep1, then a short one as DATA1
      put_bytes(1, 32, 8'h00);
      check("t1_free", in_ep_data_free[1], 1);
      in_xfer("t1_in", 4'd1, P_DATA0);
      recv_bytes("t1", 8'h00, 32);
      pkt_end();
      ack_expect("t1", 11'h002);
      put_bytes(1, 2, 8'h40);
      commit(1);
      in_xfer("t1b_in", 4'd1, P_DATA1);
      recv_bytes("t1b", 8'h40, 2);
      pkt_end();
      ack_expect("t1b", 11'h002);

      // Ping-pong fill on ep2; the extra put while full must be dropped
      put_bytes(2, 5, 8'hA0);
      commit(2);
      put_bytes(2, 3, 8'hB0);
      commit(2);
      check("t2_full", in_ep_data_free[2], 0);
      put_bytes(2, 1, 8'hEE);
      in_xfer("t2a_in", 4'd2, P_DATA0);
      recv_bytes("t2a", 8'hA0, 5);
      pkt_end();
      rx_packet(P_ACK, 4'd0, DEV);
      check("t2a_acked", in_ep_acked, 11'h004);
      check("t2a_free", in_ep_data_free[2], 1);
      tick();
      in_xfer("t2b_in", 4'd2, P_DATA1);
      recv_bytes("t2b", 8'hB0, 3);
      pkt_end();
      ack_expect("t2b", 11'h004);

      // ACK timeout on ep5: late ACK ignored, retransmit with same PID/data
      put_bytes(5, 4, 8'hC0);
      commit(5);
      in_xfer("t3_in", 4'd5, P_DATA0);
      recv_bytes("t3", 8'hC0, 4);
      pkt_end();
      seen = '0;
      for (int i = 0; i < 20; i++) begin
         seen |= in_ep_acked;
         tick();
      end
      check("t3_no_ack_pulse", seen, 0);
      rx_packet(P_ACK, 4'd0, DEV);
      check("t3_late_ack", in_ep_acked, 0);
      in_xfer("t3r_in", 4'd5, P_DATA0);
      recv_bytes("t3r", 8'hC0, 4);
      pkt_end();
      ack_expect("t3r", 11'h020);

      // Stall then SETUP on ep3
      in_ep_stall = 11'h008;
      tick();
      in_ep_stall = '0;
      check("t4_free_stalled", in_ep_data_free[3], 0);
      in_xfer("t4_stall", 4'd3, P_STALL);
      rx_packet(P_SETUP, 4'd3, DEV);
      check("t4_free_setup", in_ep_data_free[3], 1);
      in_xfer("t4_nak", 4'd3, P_NAK);
      put_bytes(3, 2, 8'h30);
      commit(3);
      in_xfer("t4_data", 4'd3, P_DATA1);
      recv_bytes("t4", 8'h30, 2);
      pkt_end();
      ack_expect("t4", 11'h008);

      // Isochronous ep4: empty gives zero-length DATA0, data released on tx end
      in_xfer("t5_zlp", 4'd4, P_DATA0);
      check("t5_zlp_avail", tx_data_avail, 0);
      pkt_end();
      check("t5_zlp_acked", in_ep_acked, 0);
      put_bytes(4, 7, 8'hD0);
      commit(4);
      in_xfer("t5_in", 4'd4, P_DATA0);
      recv_bytes("t5", 8'hD0, 7);
      pkt_end();
      check("t5_acked", in_ep_acked, 11'h010);
      tick();
      check("t5_acked_low", in_ep_acked, 0);

      // Wrong address ignored; reset in the middle of a transfer
      rx_packet(P_IN, 4'd1, 7'h11);
      check("t6_wrong_addr", tx_pkt_start, 0);
      put_bytes(1, 3, 8'h50);
      commit(1);
      in_xfer("t6_in", 4'd1, P_DATA0);
      check("t6_avail", tx_data_avail, 1);
      tx_data_get = 1'b1;
      tick();
      tx_data_get = 1'b0;
      reset = 1'b1;
      tick();
      check("t6_rst_start", tx_pkt_start, 0);
      check("t6_rst_pid", tx_pid, 0);
      check("t6_rst_data", tx_data, 0);
      check("t6_rst_avail", tx_data_avail, 0);
      check("t6_rst_acked", in_ep_acked, 0);
      check("t6_rst_free", in_ep_data_free, 0);
      reset = 1'b0;
      tick();
      tick();
      in_xfer("t6_nak", 4'd1, P_NAK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
